ascii_msg_tx: RTL and testbench
===============================

// Module: ascii_msg_tx
// PURPOSE
// - Outbound text path of the ATM console; the reverse of the keypad ASCII-to-binary input path.
// - Takes a 4-bit status code plus an optional 16-bit value (4 nibbles, digit 0 in [3:0]).
// - Serialises them as an ASCII line, one byte per valid/ready handshake, to the UART TX or display driver.
// PARAMETERS
// - NUM_DIGITS   4   value nibbles emitted; fixed at 4 to match the 16-bit acct/pswd fields
// - HEX_DIGITS   1   1: nibbles 10..15 map to 'A'..'F'; 0: they map to '?' (0x3F)
// PORTS
// - clk           in   1   system clock; the only clock
// - rst_n         in   1   reset, asynchronous, active-low
// - start         in   1   single-cycle request; sampled only when busy=0
// - status_code   in   4   message selector (status codes from atm_pkg)
// - show_val      in   1   1: append ' ' and NUM_DIGITS digits after the tag
// - value         in   16  value to print; nibble 0 [3:0] is emitted first (typed order)
// - tx_data       out  8   ASCII byte; stable while tx_valid=1 and tx_ready=0
// - tx_valid      out  1   tx_data is valid
// - tx_ready      in   1   sink accepts the byte when tx_valid & tx_ready
// - busy          out  1   high from the cycle after start is accepted until the line completes
// - done          out  1   one-cycle pulse after the LF byte is accepted
// BEHAVIOUR
// - Reset: tx_data=8'h00, tx_valid=0, busy=0, done=0, FSM=IDLE, index=0. All latched inputs cleared.
// - Reset mid-line aborts immediately. No further bytes are sent, and done is not pulsed.
// - Accept: start=1 with busy=0 latches status_code, show_val and value.
//   - busy=1 and tx_valid=1 with the first tag byte on the next cycle (1-cycle latency).
// - start while busy=1 is ignored. This includes the cycle of the final LF handshake.
// - Handshake:
//   - tx_valid stays high until accepted; tx_data must not change while waiting.
//   - The next byte appears the cycle after acceptance, so max throughput is 1 byte per 2 cycles is NOT allowed.
//   - Throughput is 1 byte per cycle when tx_ready is held high: the next byte is presented in the cycle following the handshake.
//   - tx_valid never drops mid-line.
// - FSM: IDLE -> TAG(4 bytes) -> [SEP(1) -> DIGIT(NUM_DIGITS)] -> CR -> LF -> IDLE.
//   - SEP and DIGIT are skipped when the latched show_val=0.
//   - A 2-bit index counts within TAG and DIGIT, advances only on handshake, and wraps to 0 on exit.
// - Tag ROM (4 chars):
//   - 1 "ACOK", 2 "ACNF", 3 "PNOK", 4 "PNBD", 5 "AMOK", 6 "AMBD", 7 "EXIT", 8 "DONE".
//   - 0 and 9..15 all print "ERR?".
// - SEP=0x20, CR=0x0D, LF=0x0A.
// - Digit mapping:
//   - nibble 0..9 -> 8'h30+n.
//   - nibble 10..15 -> 8'h41+(n-10) if HEX_DIGITS, else 8'h3F.
// - Line length is 6 bytes (show_val=0) or 11 bytes (show_val=1).
// - End of line: the LF handshake returns the FSM to IDLE.
//   - Next cycle: done=1, busy=0, tx_valid=0.
//   - A start in that same done cycle is accepted.
// - Inputs changing after acceptance have no effect on the line in flight.
// STRUCTURE
// - atm_pkg holds the shared constants:
//   - status code values (ACC_FOUND..INPUT_COMPLETE).
//   - ASCII constants: CR, LF, SPACE, '0', 'A', '?'.
//   - the FSM state enum.
// - Sub-module nibble_to_ascii: combinational, 4-bit in, 8-bit out, parameter HEX_DIGITS.
// - Tag ROM is a case statement inside ascii_msg_tx; no separate memory.
// TESTING
// - Reset, then start with code=1, show_val=1, value=16'h4321, tx_ready=1:
//   - bytes 41 43 4F 4B 20 31 32 33 34 0D 0A on consecutive cycles.
//   - done 1 cycle after 0A.
// - code=7, show_val=0, tx_ready toggling 1/0 each cycle:
//   - "EXIT\r\n", 6 bytes.
//   - tx_data held stable whenever tx_ready=0.
// - value=16'h00FA with HEX_DIGITS=1 -> digits 'A','F','0','0'; with HEX_DIGITS=0 -> '?','?','0','0'.
// - start pulsed at byte 3 and again during the LF handshake -> both ignored; a start in the done cycle launches a new line.
// - rst_n low while the digit-2 byte is pending -> tx_valid=0, busy=0, done=0 immediately; the next line starts from a clean tag.
// - code=0 and code=12 -> "ERR?" tag.

Source files
------------

// File: rtl/atm_pkg.sv
// Shared ATM console constants: status codes, ASCII characters and the
// serialiser state encoding.
package atm_pkg;

    localparam int unsigned CODE_W  = 4;
    localparam int unsigned VALUE_W = 16;
    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned IDX_W   = 2;

    localparam logic [CODE_W-1:0] ACC_FOUND      = 4'd1;
    localparam logic [CODE_W-1:0] ACC_NOT_FOUND  = 4'd2;
    localparam logic [CODE_W-1:0] PIN_OK         = 4'd3;
    localparam logic [CODE_W-1:0] PIN_BAD        = 4'd4;
    localparam logic [CODE_W-1:0] AMT_OK         = 4'd5;
    localparam logic [CODE_W-1:0] AMT_BAD        = 4'd6;
    localparam logic [CODE_W-1:0] USER_EXIT      = 4'd7;
    localparam logic [CODE_W-1:0] INPUT_COMPLETE = 4'd8;

    localparam logic [BYTE_W-1:0] ASCII_CR    = 8'h0D;
    localparam logic [BYTE_W-1:0] ASCII_LF    = 8'h0A;
    localparam logic [BYTE_W-1:0] ASCII_SPACE = 8'h20;
    localparam logic [BYTE_W-1:0] ASCII_ZERO  = 8'h30;
    localparam logic [BYTE_W-1:0] ASCII_A     = 8'h41;
    localparam logic [BYTE_W-1:0] ASCII_QMARK = 8'h3F;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TAG,
        ST_SEP,
        ST_DIGIT,
        ST_CR,
        ST_LF
    } tx_state_t;

endpackage

// File: rtl/nibble_to_ascii.sv
// Combinational nibble-to-ASCII digit converter; non-decimal nibbles become
// hex letters or '?' depending on HEX_DIGITS.
module nibble_to_ascii
    import atm_pkg::*;
#(
    parameter bit HEX_DIGITS = 1'b1
) (
    input  logic [3:0]        nibble,
    output logic [BYTE_W-1:0] ascii_c
);

    always_comb begin
        ascii_c = ASCII_QMARK;
        if (nibble < 4'd10) begin
            ascii_c = ASCII_ZERO + BYTE_W'(nibble);
        end else if (HEX_DIGITS) begin
            ascii_c = ASCII_A + BYTE_W'(nibble - 4'd10);
        end
    end

endmodule

// File: rtl/ascii_msg_tx.sv
// Serialises a status tag, an optional 4-digit value and CR/LF as an ASCII
// line, one byte per valid/ready handshake.
module ascii_msg_tx
    import atm_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 4,
    parameter bit          HEX_DIGITS = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [CODE_W-1:0]  status_code,
    input  logic               show_val,
    input  logic [VALUE_W-1:0] value,
    output logic [BYTE_W-1:0]  tx_data,
    output logic               tx_valid,
    input  logic               tx_ready,
    output logic               busy,
    output logic               done
);

    localparam logic [IDX_W-1:0] LAST_TAG   = 2'd3;
    localparam logic [IDX_W-1:0] LAST_DIGIT = IDX_W'(NUM_DIGITS - 1);

    tx_state_t          state;
    tx_state_t          nxt_state;
    logic [IDX_W-1:0]   idx;
    logic [IDX_W-1:0]   nxt_idx;
    logic [CODE_W-1:0]  code_q;
    logic               show_q;
    logic [VALUE_W-1:0] value_q;
    logic [3:0]         digit_nibble;
    logic [BYTE_W-1:0]  digit_c;
    logic [BYTE_W-1:0]  nxt_byte;

    // Tag ROM: 4 characters per status code, leftmost character at pos 0.
    function automatic logic [BYTE_W-1:0] tag_char(input logic [CODE_W-1:0] code,
                                                   input logic [IDX_W-1:0]  pos);
        logic [31:0] word;
        case (code)
            ACC_FOUND:      word = "ACOK";
            ACC_NOT_FOUND:  word = "ACNF";
            PIN_OK:         word = "PNOK";
            PIN_BAD:        word = "PNBD";
            AMT_OK:         word = "AMOK";
            AMT_BAD:        word = "AMBD";
            USER_EXIT:      word = "EXIT";
            INPUT_COMPLETE: word = "DONE";
            default:        word = "ERR?";
        endcase
        case (pos)
            2'd0:    return word[31:24];
            2'd1:    return word[23:16];
            2'd2:    return word[15:8];
            default: return word[7:0];
        endcase
    endfunction

    nibble_to_ascii #(.HEX_DIGITS(HEX_DIGITS)) u_digit (
        .nibble  (digit_nibble),
        .ascii_c (digit_c)
    );

    // Position and byte that follow the one currently presented.
    always_comb begin
        nxt_state    = state;
        nxt_idx      = idx;
        digit_nibble = value_q[3:0];
        nxt_byte     = 8'h00;
        case (state)
            ST_TAG: begin
                if (idx == LAST_TAG) begin
                    nxt_idx   = '0;
                    nxt_state = show_q ? ST_SEP : ST_CR;
                end else begin
                    nxt_idx = idx + 2'd1;
                end
            end
            ST_SEP: begin
                nxt_idx   = '0;
                nxt_state = ST_DIGIT;
            end
            ST_DIGIT: begin
                if (idx == LAST_DIGIT) begin
                    nxt_idx   = '0;
                    nxt_state = ST_CR;
                end else begin
                    nxt_idx = idx + 2'd1;
                end
            end
            ST_CR:   nxt_state = ST_LF;
            ST_LF:   nxt_state = ST_IDLE;
            default: nxt_state = ST_IDLE;
        endcase
        case (nxt_idx)
            2'd0:    digit_nibble = value_q[3:0];
            2'd1:    digit_nibble = value_q[7:4];
            2'd2:    digit_nibble = value_q[11:8];
            default: digit_nibble = value_q[15:12];
        endcase
        case (nxt_state)
            ST_TAG:   nxt_byte = tag_char(code_q, nxt_idx);
            ST_SEP:   nxt_byte = ASCII_SPACE;
            ST_DIGIT: nxt_byte = digit_c;
            ST_CR:    nxt_byte = ASCII_CR;
            ST_LF:    nxt_byte = ASCII_LF;
            default:  nxt_byte = 8'h00;
        endcase
    end

    // Line sequencer; tx_data is reloaded in the handshake cycle so a held-high
    // tx_ready sustains one byte per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            idx      <= '0;
            code_q   <= '0;
            show_q   <= 1'b0;
            value_q  <= '0;
            tx_data  <= 8'h00;
            tx_valid <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (!busy) begin
                if (start) begin
                    code_q   <= status_code;
                    show_q   <= show_val;
                    value_q  <= value;
                    state    <= ST_TAG;
                    idx      <= '0;
                    tx_data  <= tag_char(status_code, 2'd0);
                    tx_valid <= 1'b1;
                    busy     <= 1'b1;
                end
            end else if (tx_valid && tx_ready) begin
                state <= nxt_state;
                idx   <= nxt_idx;
                if (nxt_state == ST_IDLE) begin
                    tx_valid <= 1'b0;
                    busy     <= 1'b0;
                    done     <= 1'b1;
                end else begin
                    tx_data <= nxt_byte;
                end
            end
        end
    end

endmodule

// File: tb/tb_ascii_msg_tx.sv
// Bench for ascii_msg_tx: a line-level byte-queue model checked every cycle
// against a hex and a non-hex instance, plus literal line expectations.
module tb_ascii_msg_tx;

    typedef logic [7:0] bq_t[$];

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  status_code = 4'd0;
    logic        show_val = 1'b0;
    logic [15:0] value = 16'h0000;
    logic        tx_ready = 1'b1;

    logic [7:0]  tx_data_h, tx_data_n;
    logic        tx_valid_h, tx_valid_n, busy_h, busy_n, done_h, done_n;

    int total = 0;
    int passed = 0;
    int cyc = 0;

    bq_t  qh, qn, rec_h, rec_n;
    int   rec_t[$];
    logic m_valid = 1'b0, m_busy = 1'b0, m_done = 1'b0;
    logic stall_prev = 1'b0;
    logic [7:0] data_prev = 8'h00;

    always #5 clk = ~clk;

    ascii_msg_tx #(.NUM_DIGITS(4), .HEX_DIGITS(1'b1)) dut_h (
        .clk(clk), .rst_n(rst_n), .start(start), .status_code(status_code),
        .show_val(show_val), .value(value), .tx_data(tx_data_h),
        .tx_valid(tx_valid_h), .tx_ready(tx_ready), .busy(busy_h), .done(done_h)
    );

    ascii_msg_tx #(.NUM_DIGITS(4), .HEX_DIGITS(1'b0)) dut_n (
        .clk(clk), .rst_n(rst_n), .start(start), .status_code(status_code),
        .show_val(show_val), .value(value), .tx_data(tx_data_n),
        .tx_valid(tx_valid_n), .tx_ready(tx_ready), .busy(busy_n), .done(done_n)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        else passed++;
    endtask

    // Expected line as a byte list, straight from the message format rules.
    function automatic bq_t build(input logic [3:0] code, input logic show,
                                  input logic [15:0] val, input bit hex);
        bq_t   q;
        string t;
        int    n;
        case (code)
            1: t = "ACOK"; 2: t = "ACNF"; 3: t = "PNOK"; 4: t = "PNBD";
            5: t = "AMOK"; 6: t = "AMBD"; 7: t = "EXIT"; 8: t = "DONE";
            default: t = "ERR?";
        endcase
        for (int i = 0; i < 4; i++) q.push_back(t[i]);
        if (show) begin
            q.push_back(8'h20);
            for (int i = 0; i < 4; i++) begin
                n = int'((val >> (4 * i)) & 16'hF);
                if (n < 10)   q.push_back(8'(48 + n));
                else if (hex) q.push_back(8'(65 + n - 10));
                else          q.push_back(8'h3F);
            end
        end
        q.push_back(8'h0D);
        q.push_back(8'h0A);
        return q;
    endfunction

    // Model: pops a byte per handshake, loads a new line on an accepted start.
    always @(posedge clk or negedge rst_n) begin
        bq_t tmp;
        if (!rst_n) begin
            qh.delete(); qn.delete();
            m_valid <= 1'b0; m_busy <= 1'b0; m_done <= 1'b0;
        end else begin
            m_done <= 1'b0;
            if (m_valid && tx_ready) begin
                void'(qh.pop_front());
                void'(qn.pop_front());
                if (qh.size() == 0) begin
                    m_valid <= 1'b0; m_busy <= 1'b0; m_done <= 1'b1;
                end
            end else if (!m_busy && start) begin
                tmp = build(status_code, show_val, value, 1'b1);
                foreach (tmp[i]) qh.push_back(tmp[i]);
                tmp = build(status_code, show_val, value, 1'b0);
                foreach (tmp[i]) qn.push_back(tmp[i]);
                m_valid <= 1'b1; m_busy <= 1'b1;
            end
        end
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        stall_prev <= rst_n && tx_valid_h && !tx_ready;
        data_prev  <= tx_data_h;
        if (rst_n && tx_valid_h && tx_ready) begin
            rec_h.push_back(tx_data_h);
            rec_t.push_back(cyc);
        end
        if (rst_n && tx_valid_n && tx_ready) rec_n.push_back(tx_data_n);
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("valid_h", 64'(tx_valid_h), 64'(m_valid));
            chk("valid_n", 64'(tx_valid_n), 64'(m_valid));
            chk("busy_h", 64'(busy_h), 64'(m_busy));
            chk("busy_n", 64'(busy_n), 64'(m_busy));
            chk("done_h", 64'(done_h), 64'(m_done));
            chk("done_n", 64'(done_n), 64'(m_done));
            if (m_valid && qh.size() > 0) begin
                chk("data_h", 64'(tx_data_h), 64'(qh[0]));
                chk("data_n", 64'(tx_data_n), 64'(qn[0]));
            end
            if (stall_prev) chk("hold_data", 64'(tx_data_h), 64'(data_prev));
        end
    end

    task automatic send(input logic [3:0] code, input logic show, input logic [15:0] val);
        @(negedge clk);
        start = 1'b1; status_code = code; show_val = show; value = val;
        @(negedge clk);
        start = 1'b0; status_code = ~code; show_val = ~show; value = ~val;
    endtask

    task automatic wait_done(input int budget);
        logic seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            if (done_h) seen = 1'b1;
            else @(negedge clk);
        end
        chk("done_within_budget", 64'(seen), 64'd1);
        @(negedge clk);
    endtask

    function automatic logic [31:0] rec4(input int base, input bit hexq);
        if (hexq) return {rec_h[base], rec_h[base+1], rec_h[base+2], rec_h[base+3]};
        else      return {rec_n[base], rec_n[base+1], rec_n[base+2], rec_n[base+3]};
    endfunction

    task automatic clr();
        rec_h.delete(); rec_n.delete(); rec_t.delete();
    endtask

    initial begin
        bq_t pin;
        logic [7:0] lit1 [11] = '{8'h41, 8'h43, 8'h4F, 8'h4B, 8'h20, 8'h31,
                                  8'h32, 8'h33, 8'h34, 8'h0D, 8'h0A};

        // Model pinned against hand-written lines.
        pin = build(4'd7, 1'b0, 16'h0000, 1'b1);
        chk("model_exit_len", 64'(pin.size()), 64'd6);
        chk("model_exit", {16'h0, pin[0], pin[1], pin[2], pin[3], pin[4], pin[5]}, 64'h455849540D0A);
        pin = build(4'd5, 1'b1, 16'h00FA, 1'b0);
        chk("model_nohex", {pin[5], pin[6], pin[7], pin[8]}, 64'h3F3F3030);

        // Reset state.
        repeat (3) @(negedge clk);
        chk("rst_data", 64'(tx_data_h), 64'h00);
        chk("rst_valid", 64'(tx_valid_h), 64'd0);
        chk("rst_busy", 64'(busy_h), 64'd0);
        chk("rst_done", 64'(done_h), 64'd0);
        rst_n = 1'b1;

        // Full-rate line with value.
        clr();
        send(4'd1, 1'b1, 16'h4321);
        wait_done(40);
        chk("l1_len", 64'(rec_h.size()), 64'd11);
        if (rec_h.size() == 11) begin
            for (int i = 0; i < 11; i++) chk("l1_byte", 64'(rec_h[i]), 64'(lit1[i]));
            chk("l1_back_to_back", 64'(rec_t[10] - rec_t[0]), 64'd10);
        end

        // Toggling ready, no value.
        clr();
        send(4'd7, 1'b0, 16'h1234);
        begin
            logic seen = 1'b0;
            for (int i = 0; i < 40 && !seen; i++) begin
                if (done_h) seen = 1'b1;
                else begin tx_ready = ~tx_ready; @(negedge clk); end
            end
            chk("exit_done_seen", 64'(seen), 64'd1);
        end
        tx_ready = 1'b1;
        @(negedge clk);
        chk("exit_len", 64'(rec_h.size()), 64'd6);
        if (rec_h.size() == 6) chk("exit_tag", 64'(rec4(0, 1'b1)), 64'h45584954);

        // Hex versus non-hex digits.
        clr();
        send(4'd5, 1'b1, 16'h00FA);
        wait_done(40);
        if (rec_h.size() == 11 && rec_n.size() == 11) begin
            chk("hex_digits", 64'(rec4(5, 1'b1)), 64'h41463030);
            chk("nohex_digits", 64'(rec4(5, 1'b0)), 64'h3F3F3030);
        end else chk("hex_len", 64'(rec_h.size()), 64'd11);

        // Starts while busy ignored, start in done cycle accepted.
        clr();
        send(4'd3, 1'b0, 16'h0000);
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            start = (c == 2 || c == 5 || c == 6);
            status_code = (c == 6) ? 4'd8 : 4'd2;
            show_val = 1'b0;
        end
        @(negedge clk);
        start = 1'b0;
        wait_done(40);
        chk("two_lines_len", 64'(rec_h.size()), 64'd12);
        if (rec_h.size() == 12) begin
            chk("line_a_tag", 64'(rec4(0, 1'b1)), 64'h504E4F4B);
            chk("line_b_tag", 64'(rec4(6, 1'b1)), 64'h444F4E45);
        end

        // Reset while digit 2 pending.
        clr();
        send(4'd2, 1'b1, 16'h9876);
        repeat (7) @(negedge clk);
        tx_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("abort_valid", 64'(tx_valid_h), 64'd0);
        chk("abort_busy", 64'(busy_h), 64'd0);
        chk("abort_done", 64'(done_h), 64'd0);
        chk("abort_sent", 64'(rec_h.size()), 64'd7);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tx_ready = 1'b1;
        clr();
        send(4'd4, 1'b0, 16'h0000);
        wait_done(40);
        chk("post_rst_len", 64'(rec_h.size()), 64'd6);
        if (rec_h.size() == 6) chk("post_rst_tag", 64'(rec4(0, 1'b1)), 64'h504E4244);

        // Error tags.
        clr();
        send(4'd0, 1'b0, 16'h0000);
        wait_done(40);
        send(4'd12, 1'b0, 16'h0000);
        wait_done(40);
        chk("err_len", 64'(rec_h.size()), 64'd12);
        if (rec_h.size() == 12) begin
            chk("err_tag0", 64'(rec4(0, 1'b1)), 64'h4552523F);
            chk("err_tag12", 64'(rec4(6, 1'b1)), 64'h4552523F);
        end

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
